and3_resp_checker: RTL and testbench

AND3_RESP_CHECKER -- requirements
Module: and3_resp_checker

---
 rtl/chk_pkg.sv | 32 +++
 rtl/chk_delay_line.sv | 58 +++++
 rtl/and3_resp_checker.sv | 153 +++++++++++++++
 tb/tb_and3_resp_checker.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/chk_pkg.sv
// ============================================================================
// Module      : chk_pkg
// Description : Definitions shared by the AND3 response checker files.
//               These are the FSM state type, the latency limit, the default
//               counter width and a DRAIN length helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package chk_pkg;

  // Checker phases. The checker resets into ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } chk_state_t;

  localparam int LATENCY_MAX   = 4;
  localparam int CNT_W_DEFAULT = 16;

  // Number of cycles spent in DRAIN. A sample launched in the stop cycle
  // emerges LATENCY cycles later. LATENCY=0 still takes one DRAIN cycle.
  function automatic int drain_len(input int lat);
    return (lat == 0) ? 1 : lat;
  endfunction

endpackage

`default_nettype wire

// File: rtl/chk_delay_line.sv
// ============================================================================
// Module      : chk_delay_line
// Description : DEPTH-stage shift line that carries one data bit together
//               with its valid bit. DEPTH=0 is a combinational pass-through.
//               The clear input drops every in-flight valid bit.
// Ports       : clk, rst       - clock, asynchronous active-high reset
//               clear          - synchronous flush of the valid bits
//               data_in/valid_in   - entry launched this cycle
//               data_out/valid_out - entry emerging this cycle
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chk_delay_line #(
  parameter int DEPTH = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic data_in,
  input  logic valid_in,
  output logic data_out,
  output logic valid_out
);

  if (DEPTH == 0) begin : g_bypass
    // No storage is needed here, so the clock, reset and clear inputs are unused.
    logic unused_ctrl;
    assign unused_ctrl = clk ^ rst ^ clear;
    assign data_out    = data_in;
    assign valid_out   = valid_in;
  end else begin : g_pipe
    logic [DEPTH-1:0] data_sr;
    logic [DEPTH-1:0] valid_sr;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_sr  <= '0;
        valid_sr <= '0;
      end else if (clear) begin
        valid_sr <= '0;
      end else begin
        data_sr[0]  <= data_in;
        valid_sr[0] <= valid_in;
        for (int i = 1; i < DEPTH; i++) begin
          data_sr[i]  <= data_sr[i-1];
          valid_sr[i] <= valid_sr[i-1];
        end
      end
    end

    assign data_out  = data_sr[DEPTH-1];
    assign valid_out = valid_sr[DEPTH-1];
  end

endmodule

`default_nettype wire

// File: rtl/and3_resp_checker.sv
// ============================================================================
// Module      : and3_resp_checker
// Description : Checks a 3-input AND DUT. The expected value x&y&u is
//               delayed by LATENCY cycles and compared with the response z.
//               The block counts comparisons and mismatches, and sets a
//               sticky fail flag on any mismatch.
// Ports       : clk, rst            - clock, asynchronous active-high reset
//               start, stop         - one-cycle control pulses
//               sample_valid, x,y,u - qualified DUT stimulus
//               z                   - DUT response under check
//               busy, done, fail    - status (RUN|DRAIN, DONE, sticky error)
//               check_cnt, err_cnt  - saturating comparison/mismatch counts
//               first_err_idx, first_err_z - present only when the macro
//                 AND3_CHK_FIRST_ERR_EN is defined
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module and3_resp_checker
  import chk_pkg::*;
#(
  parameter int LATENCY = 0,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             sample_valid,
  input  logic             x,
  input  logic             y,
  input  logic             u,
  input  logic             z,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [CNT_W-1:0] check_cnt,
`ifdef AND3_CHK_FIRST_ERR_EN
  output logic [CNT_W-1:0] first_err_idx,
  output logic             first_err_z,
`endif
  output logic [CNT_W-1:0] err_cnt
);

  localparam int               DRAIN_LEN = drain_len(LATENCY);
  localparam logic [2:0]       DRAIN_END = 3'(DRAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  chk_state_t state;
  logic [2:0] drain_cnt;

  logic expected;
  logic launch;
  logic exp_dly;
  logic exp_vld;
  logic compare;
  logic mismatch;

  assign expected = x & y & u;
  // Samples are launched only in RUN. DRAIN lets the line empty.
  assign launch   = (state == ST_RUN) && sample_valid;

  // A start pulse restarts the check run, so it also flushes the line.
  chk_delay_line #(
    .DEPTH (LATENCY)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .clear     (start),
    .data_in   (expected),
    .valid_in  (launch),
    .data_out  (exp_dly),
    .valid_out (exp_vld)
  );

  assign compare  = ((state == ST_RUN) || (state == ST_DRAIN)) && exp_vld;
  assign mismatch = compare && (exp_dly != z);

  // Control FSM. busy and done are registered with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      drain_cnt <= '0;
    end else if (start) begin
      // start wins over stop and restarts from any state
      state     <= ST_RUN;
      busy      <= 1'b1;
      done      <= 1'b0;
      drain_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (stop) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == DRAIN_END) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end
        default: ;  // IDLE and DONE only leave on start
      endcase
    end
  end

  // Result counters. A comparison in a start cycle is dropped because the
  // counters clear in that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      check_cnt <= '0;
      err_cnt   <= '0;
      fail      <= 1'b0;
    end else if (start) begin
      check_cnt <= '0;
      err_cnt   <= '0;
      fail      <= 1'b0;
    end else if (compare) begin
      if (check_cnt != CNT_MAX) check_cnt <= check_cnt + CNT_ONE;
      if (mismatch) begin
        if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_ONE;
        fail <= 1'b1;
      end
    end
  end

`ifdef AND3_CHK_FIRST_ERR_EN
  // fail is still low at the first mismatch, so it selects the capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_err_idx <= '0;
      first_err_z   <= 1'b0;
    end else if (start) begin
      first_err_idx <= '0;
      first_err_z   <= 1'b0;
    end else if (mismatch && !fail) begin
      first_err_idx <= check_cnt;
      first_err_z   <= z;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_and3_resp_checker.sv
// ============================================================================
// Module      : tb_and3_resp_checker
// Description : Self-checking bench for and3_resp_checker. It builds four
//               instances: LATENCY 0/2/3/1, with CNT_W 16/16/16/3. A bench
//               reference model counts the samples launched while running.
//               The bench plays the DUT under check: z is x&y&u delayed by
//               LATENCY, optionally inverted. The macro AND3_CHK_FIRST_ERR_EN
//               adds first-error checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_and3_resp_checker;

  localparam int LAT[4] = '{0, 2, 3, 1};
  localparam int CW[4]  = '{16, 16, 16, 3};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        st[4], sp[4], sv[4], xi[4], yi[4], ui[4], zi[4];
  logic        busy[4], done[4], fl[4];
  logic [31:0] cc[4], ec[4];
`ifdef AND3_CHK_FIRST_ERR_EN
  logic [31:0] fei[4];
  logic        fez[4];
`endif

  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic [CW[g]-1:0] cc_l, ec_l;
`ifdef AND3_CHK_FIRST_ERR_EN
    logic [CW[g]-1:0] fei_l;
`endif
    and3_resp_checker #(.LATENCY(LAT[g]), .CNT_W(CW[g])) u_dut (
      .clk          (clk),
      .rst          (rst),
      .start        (st[g]),
      .stop         (sp[g]),
      .sample_valid (sv[g]),
      .x            (xi[g]),
      .y            (yi[g]),
      .u            (ui[g]),
      .z            (zi[g]),
      .busy         (busy[g]),
      .done         (done[g]),
      .fail         (fl[g]),
      .check_cnt    (cc_l),
`ifdef AND3_CHK_FIRST_ERR_EN
      .first_err_idx(fei_l),
      .first_err_z  (fez[g]),
`endif
      .err_cnt      (ec_l)
    );
    assign cc[g] = 32'(cc_l);
    assign ec[g] = 32'(ec_l);
`ifdef AND3_CHK_FIRST_ERR_EN
    assign fei[g] = 32'(fei_l);
`endif
  end

  int tests = 0;
  int fails = 0;

  // Reference model state for each instance
  int m_chk[4], m_err[4], m_fei[4];
  bit m_fail[4], m_run[4], m_fe[4], m_fez[4];
  bit zh[4][4];  // recent (expected ^ inject) values, newest at [0]

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input int d);
    m_chk[d] = 0; m_err[d] = 0; m_fei[d] = 0;
    m_fail[d] = 0; m_fe[d] = 0; m_fez[d] = 0;
  endtask

  // One clock cycle of stimulus for instance d. bad=1 inverts the response.
  task automatic drive(input int d, input bit s, input bit p, input bit v,
                       input bit [2:0] xyu, input bit bad);
    bit e, zv;
    int mx;
    e  = &xyu;
    mx = (1 << CW[d]) - 1;
    if (LAT[d] == 0) zv = e ^ bad;
    else             zv = zh[d][LAT[d]-1];
    for (int i = 3; i > 0; i--) zh[d][i] = zh[d][i-1];
    zh[d][0] = v ? (e ^ bad) : 1'b0;
    st[d] = s; sp[d] = p; sv[d] = v;
    xi[d] = xyu[2]; yi[d] = xyu[1]; ui[d] = xyu[0]; zi[d] = zv;
    if (s) begin
      model_clear(d);
      m_run[d] = 1;
    end else begin
      if (m_run[d] && v) begin
        if (bad && !m_fe[d]) begin
          m_fe[d] = 1; m_fei[d] = m_chk[d]; m_fez[d] = ~e;
        end
        if (m_chk[d] < mx) m_chk[d]++;
        if (bad) begin
          if (m_err[d] < mx) m_err[d]++;
          m_fail[d] = 1;
        end
      end
      if (p) m_run[d] = 0;
    end
    @(posedge clk); #1;
    st[d] = 0; sp[d] = 0; sv[d] = 0;
  endtask

  task automatic chk_results(input int d, input string tag);
    chk($sformatf("%s_check_cnt", tag), cc[d], m_chk[d]);
    chk($sformatf("%s_err_cnt", tag), ec[d], m_err[d]);
    chk($sformatf("%s_fail", tag), fl[d], m_fail[d]);
`ifdef AND3_CHK_FIRST_ERR_EN
    chk($sformatf("%s_first_err_idx", tag), fei[d], m_fe[d] ? m_fei[d] : 0);
    chk($sformatf("%s_first_err_z", tag), fez[d], m_fe[d] ? m_fez[d] : 1'b0);
`endif
  endtask

  // Pulse stop, then check the exact DRAIN length and the final results.
  task automatic stop_and_drain(input int d, input string tag);
    int n;
    n = (LAT[d] == 0) ? 1 : LAT[d];
    drive(d, 0, 1, 0, 3'b000, 0);
    chk($sformatf("%s_drain_busy", tag), busy[d], 1);
    chk($sformatf("%s_drain_done", tag), done[d], 0);
    for (int i = 1; i <= n; i++) begin
      drive(d, 0, 0, 0, 3'b000, 0);
      chk($sformatf("%s_done_c%0d", tag, i), done[d], (i == n));
      chk($sformatf("%s_busy_c%0d", tag, i), busy[d], (i != n));
    end
    chk_results(d, tag);
  endtask

  task automatic chk_zero(input int d, input string tag);
    chk($sformatf("%s_busy", tag), busy[d], 0);
    chk($sformatf("%s_done", tag), done[d], 0);
    chk($sformatf("%s_fail", tag), fl[d], 0);
    chk($sformatf("%s_check_cnt", tag), cc[d], 0);
    chk($sformatf("%s_err_cnt", tag), ec[d], 0);
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 4; d++) begin
      st[d] = 0; sp[d] = 0; sv[d] = 0; xi[d] = 0; yi[d] = 0; ui[d] = 0; zi[d] = 0;
      model_clear(d);
      m_run[d] = 0;
      for (int i = 0; i < 4; i++) zh[d][i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) chk_zero(d, $sformatf("reset%0d", d));
    rst = 1'b0;

    // stop while IDLE is ignored
    drive(2, 0, 1, 0, 3'b000, 0);
    chk("idle_stop_busy", busy[2], 0);
    chk("idle_stop_done", done[2], 0);

    // LATENCY=0, all eight xyu combinations answered correctly
    drive(0, 1, 0, 0, 3'b000, 0);
    chk("l0_start_busy", busy[0], 1);
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 1, 3'(i), 0);
    stop_and_drain(0, "l0_all8");

    // stop in DONE is ignored and the results hold
    drive(0, 0, 1, 0, 3'b000, 0);
    chk("done_stop_done", done[0], 1);
    chk_results(0, "done_hold");

    // LATENCY=0, z stuck at 0 with xyu=111
    drive(0, 1, 0, 0, 3'b000, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 3'b111, 1);
    stop_and_drain(0, "l0_stuck0");

    // start and stop together in DONE: start wins and the counters clear
    drive(0, 1, 1, 0, 3'b000, 0);
    chk("startstop_busy", busy[0], 1);
    chk("startstop_done", done[0], 0);
    chk_results(0, "startstop");
    stop_and_drain(0, "startstop_end");

    // LATENCY=2, ten correct samples, stop right after the last
    drive(1, 1, 0, 0, 3'b000, 0);
    for (int i = 0; i < 10; i++) drive(1, 0, 0, 1, 3'($urandom), 0);
    stop_and_drain(1, "l2_ten");

    // restart while busy: in-flight bad samples are discarded
    drive(1, 1, 0, 0, 3'b000, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 1, 3'b111, 1);
    drive(1, 1, 0, 1, 3'b111, 1);
    chk_results(1, "restart_clear");
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 1, 3'($urandom), 0);
    stop_and_drain(1, "restart");

    // CNT_W=3: nine mismatches saturate both counters at 7
    drive(3, 1, 0, 0, 3'b000, 0);
    for (int i = 0; i < 9; i++) drive(3, 0, 0, 1, 3'($urandom), 1);
    stop_and_drain(3, "sat");

    // randomized runs on every instance
    for (int d = 0; d < 4; d++) begin
      drive(d, 1, 0, 0, 3'b000, 0);
      for (int i = 0; i < 30; i++)
        drive(d, 0, 0, ($urandom_range(0, 3) != 0), 3'($urandom), ($urandom_range(0, 4) == 0));
      stop_and_drain(d, $sformatf("rand%0d", d));
    end

    // asynchronous reset mid-RUN with LATENCY=3 and samples in flight
    drive(2, 1, 0, 0, 3'b000, 0);
    for (int i = 0; i < 5; i++) drive(2, 0, 0, 1, 3'b111, 1);
    #2 rst = 1'b1;
    #1;
    chk_zero(2, "async_rst");
    for (int d = 0; d < 4; d++) begin
      model_clear(d);
      m_run[d] = 0;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive(2, 1, 0, 0, 3'b000, 0);
    stop_and_drain(2, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
